decode_queue: RTL

- Registered, buffered successor to the combinational control-word decoder.
- Accepts fetched (ir, pc) pairs over a valid/ready handshake and decodes each into an rv32i_control_word at enqueue time.
- Holds up to DEPTH decoded words in a FIFO and presents them in order to the execute stage over a second valid/ready handshake.
- Adds illegal-instruction detection, optional M-extension gating, flush and an occupancy count; sits between IF and EX.

---
 rtl/decode_queue.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - registered RV32I decode FIFO between IF and EX
package rv32i_pkg;
    localparam logic [6:0] op_lui   = 7'b0110111;
    localparam logic [6:0] op_auipc = 7'b0010111;
    localparam logic [6:0] op_jal   = 7'b1101111;
    localparam logic [6:0] op_jalr  = 7'b1100111;
    localparam logic [6:0] op_br    = 7'b1100011;
    localparam logic [6:0] op_load  = 7'b0000011;
    localparam logic [6:0] op_store = 7'b0100011;
    localparam logic [6:0] op_imm   = 7'b0010011;
    localparam logic [6:0] op_reg   = 7'b0110011;

    localparam logic [2:0] alu_add = 3'b000;
    localparam logic [2:0] alu_sll = 3'b001;
    localparam logic [2:0] alu_sra = 3'b010;
    localparam logic [2:0] alu_sub = 3'b011;
    localparam logic [2:0] alu_xor = 3'b100;
    localparam logic [2:0] alu_srl = 3'b101;
    localparam logic [2:0] alu_or  = 3'b110;
    localparam logic [2:0] alu_and = 3'b111;

    localparam logic [2:0] cmp_beq  = 3'b000;
    localparam logic [2:0] cmp_bne  = 3'b001;
    localparam logic [2:0] cmp_blt  = 3'b100;
    localparam logic [2:0] cmp_bge  = 3'b101;
    localparam logic [2:0] cmp_bltu = 3'b110;
    localparam logic [2:0] cmp_bgeu = 3'b111;

    localparam logic alm1_rs1   = 1'b0;
    localparam logic alm1_pc    = 1'b1;
    localparam logic alm2_imm   = 1'b0;
    localparam logic alm2_rs2   = 1'b1;
    localparam logic cmpmux_rs2 = 1'b0;
    localparam logic cmpmux_imm = 1'b1;

    localparam logic [2:0] wbm_alu   = 3'd0;
    localparam logic [2:0] wbm_br    = 3'd1;
    localparam logic [2:0] wbm_imm   = 3'd2;
    localparam logic [2:0] wbm_pc4   = 3'd3;
    localparam logic [2:0] wbm_rdata = 3'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  aluop;
        logic [2:0]  cmpop;
        logic        alumux1_sel;
        logic        alumux2_sel;
        logic        cmpmux_sel;
        logic [1:0]  pcmux_sel;
        logic [2:0]  wbmux_sel;
        logic        load_regfile;
        logic        dmem_read;
        logic        dmem_write;
        logic        muldiv;
    } rv32i_control_word;
endpackage

module decode_queue
    import rv32i_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_ir,
    input  logic [31:0]                in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output rv32i_control_word          out_ctw,
    output logic                       out_illegal,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    rv32i_control_word mem_ctw [DEPTH];
    logic              mem_ill [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;

    rv32i_control_word dec;
    logic              ill;
    logic              push, pop;

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

    assign opc   = in_ir[6:0];
    assign f3    = in_ir[14:12];
    assign f7    = in_ir[31:25];
    assign i_imm = {{21{in_ir[31]}}, in_ir[30:20]};
    assign s_imm = {{21{in_ir[31]}}, in_ir[30:25], in_ir[11:7]};
    assign b_imm = {{20{in_ir[31]}}, in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
    assign u_imm = {in_ir[31:12], 12'h000};
    assign j_imm = {{12{in_ir[31]}}, in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};

    always_comb begin
        dec             = '0;
        ill             = 1'b0;
        dec.pc          = in_pc;
        dec.opcode      = opc;
        dec.funct3      = f3;
        dec.funct7      = f7;
        dec.imm         = i_imm;
        dec.aluop       = f3;
        dec.cmpop       = f3;
        dec.alumux1_sel = alm1_rs1;
        dec.alumux2_sel = alm2_imm;
        dec.cmpmux_sel  = cmpmux_rs2;
        dec.pcmux_sel   = 2'b00;
        dec.wbmux_sel   = wbm_alu;
        case (opc)
            op_lui: begin
                dec.imm          = u_imm;
                dec.rd           = in_ir[11:7];
                dec.wbmux_sel    = wbm_imm;
                dec.load_regfile = 1'b1;
            end
            op_auipc: begin
                dec.imm          = u_imm;
                dec.aluop        = alu_add;
                dec.alumux1_sel  = alm1_pc;
                dec.rd           = in_ir[11:7];
                dec.load_regfile = 1'b1;
            end
            op_jal: begin
                dec.imm          = j_imm;
                dec.aluop        = alu_add;
                dec.alumux1_sel  = alm1_pc;
                dec.pcmux_sel    = 2'b01;
                dec.wbmux_sel    = wbm_pc4;
                dec.rd           = in_ir[11:7];
                dec.load_regfile = 1'b1;
            end
            op_jalr: begin
                dec.aluop        = alu_add;
                dec.pcmux_sel    = 2'b01;
                dec.wbmux_sel    = wbm_pc4;
                dec.rs1          = in_ir[19:15];
                dec.rd           = in_ir[11:7];
                dec.load_regfile = 1'b1;
                ill              = (f3 != 3'd0);
            end
            op_br: begin
                dec.imm          = b_imm;
                dec.aluop        = alu_add;
                dec.alumux1_sel  = alm1_pc;
                dec.pcmux_sel    = 2'b10;
                dec.rs1          = in_ir[19:15];
                dec.rs2          = in_ir[24:20];
                ill              = (f3[2:1] == 2'b01);
            end
            op_load: begin
                dec.aluop        = alu_add;
                dec.dmem_read    = 1'b1;
                dec.wbmux_sel    = wbm_rdata;
                dec.rs1          = in_ir[19:15];
                dec.rd           = in_ir[11:7];
                dec.load_regfile = 1'b1;
                ill              = (f3 == 3'd3) || (f3[2:1] == 2'b11);
            end
            op_store: begin
                dec.imm          = s_imm;
                dec.aluop        = alu_add;
                dec.dmem_write   = 1'b1;
                dec.rs1          = in_ir[19:15];
                dec.rs2          = in_ir[24:20];
                ill              = (f3 >= 3'd3);
            end
            op_imm: begin
                dec.rs1          = in_ir[19:15];
                dec.rd           = in_ir[11:7];
                dec.load_regfile = 1'b1;
                case (f3)
                    3'd1: ill = (f7 != 7'h00);
                    3'd2: begin
                        dec.cmpop      = cmp_blt;
                        dec.wbmux_sel  = wbm_br;
                        dec.cmpmux_sel = cmpmux_imm;
                    end
                    3'd3: begin
                        dec.cmpop      = cmp_bltu;
                        dec.wbmux_sel  = wbm_br;
                        dec.cmpmux_sel = cmpmux_imm;
                    end
                    3'd5: begin
                        if (f7 == 7'h20)
                            dec.aluop = alu_sra;
                        else if (f7 != 7'h00)
                            ill = 1'b1;
                    end
                    default: ;
                endcase
            end
            op_reg: begin
                dec.alumux2_sel  = alm2_rs2;
                dec.rs1          = in_ir[19:15];
                dec.rs2          = in_ir[24:20];
                dec.rd           = in_ir[11:7];
                dec.load_regfile = 1'b1;
                if (f7 == 7'h01) begin
                    if (ENABLE_M)
                        dec.muldiv = 1'b1;
                    else
                        ill = 1'b1;
                end else if (f7 == 7'h20) begin
                    if (f3 == 3'd0)
                        dec.aluop = alu_sub;
                    else if (f3 == 3'd5)
                        dec.aluop = alu_sra;
                    else
                        ill = 1'b1;
                end else if (f7 != 7'h00) begin
                    ill = 1'b1;
                end else if (f3 == 3'd2) begin
                    dec.cmpop     = cmp_blt;
                    dec.wbmux_sel = wbm_br;
                end else if (f3 == 3'd3) begin
                    dec.cmpop     = cmp_bltu;
                    dec.wbmux_sel = wbm_br;
                end
            end
            default: ill = 1'b1;
        endcase
        // Illegal entries must not cause any architectural side effect in EX
        if (ill) begin
            dec.load_regfile = 1'b0;
            dec.dmem_read    = 1'b0;
            dec.dmem_write   = 1'b0;
            dec.pcmux_sel    = 2'b00;
            dec.muldiv       = 1'b0;
        end
    end

    assign in_ready    = (count < FULL);
    assign out_valid   = (count != '0);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign out_ctw     = mem_ctw[rd_ptr];
    assign out_illegal = out_valid && mem_ill[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_ctw[wr_ptr] <= dec;
            mem_ill[wr_ptr] <= ill;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end
endmodule
